// File: rtl/pc_decoder_alu16.sv
// rtl/pc_decoder_alu16.sv - program counter, instruction decoder and 16-bit ALU slice
// Optional ALU_FLAGS_EN adds zero/negative/carry/overflow flag outputs.
module pc_decoder_alu16 #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic [15:0] data_reg_a,
  input  logic [15:0] data_reg_b,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] pc_out,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  reg_dst,
  output logic [2:0]  reg_rs1,
  output logic [2:0]  reg_rs2,
  output logic [15:0] imm_se,
  output logic        reg_write,
  output logic        alu_src_imm,
  output logic        mem_write,
  output logic        mem_read,
  output logic        reg_write_back_sel,
  output logic [2:0]  comparator_ctrl,
  output logic [15:0] alu_result
`ifdef ALU_FLAGS_EN
  ,
  output logic        alu_zero,
  output logic        alu_negative,
  output logic        alu_carry,
  output logic        alu_overflow
`endif
);

  logic [3:0]  opcode;
  logic [15:0] imm6_se;
  logic [15:0] alu_b;

  assign opcode  = instr[15:12];
  assign imm6_se = {{10{instr[5]}}, instr[5:0]};

  // A pending branch only redirects when the decoded instruction is a branch/jump
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out <= PC_RESET;
    end else if (branch_taken && (comparator_ctrl != 3'b000)) begin
      pc_out <= branch_target;
    end else begin
      pc_out <= pc_out + PC_STEP;
    end
  end

  always_comb begin
    alu_ctrl           = 4'd0;
    reg_dst            = 3'd0;
    reg_rs1            = 3'd0;
    reg_rs2            = 3'd0;
    imm_se             = 16'h0000;
    reg_write          = 1'b0;
    alu_src_imm        = 1'b0;
    mem_write          = 1'b0;
    mem_read           = 1'b0;
    reg_write_back_sel = 1'b0;
    comparator_ctrl    = 3'b000;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        reg_dst   = instr[11:9];
        reg_rs1   = instr[8:6];
        reg_rs2   = instr[5:3];
        reg_write = 1'b1;
        alu_ctrl  = opcode - 4'd1;
      end
      4'h9, 4'hA: begin
        reg_dst            = instr[11:9];
        reg_rs1            = instr[8:6];
        imm_se             = imm6_se;
        alu_src_imm        = 1'b1;
        reg_write          = 1'b1;
        mem_read           = (opcode == 4'hA);
        reg_write_back_sel = (opcode == 4'hA);
      end
      4'hB: begin
        reg_rs1     = instr[8:6];
        reg_rs2     = instr[11:9];
        imm_se      = imm6_se;
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
      end
      4'hC: begin
        reg_dst     = instr[11:9];
        imm_se      = {{7{instr[8]}}, instr[8:0]};
        alu_ctrl    = 4'd8;
        alu_src_imm = 1'b1;
        reg_write   = 1'b1;
      end
      4'hD, 4'hE: begin
        reg_rs1         = instr[11:9];
        reg_rs2         = instr[8:6];
        imm_se          = imm6_se;
        comparator_ctrl = (opcode == 4'hD) ? 3'b001 : 3'b010;
      end
      4'hF: begin
        imm_se          = {4'h0, instr[11:0]};
        comparator_ctrl = 3'b100;
      end
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? imm_se : data_reg_b;

  always_comb begin
    alu_result = 16'h0000;
    case (alu_ctrl)
      4'd0: alu_result = data_reg_a + alu_b;
      4'd1: alu_result = data_reg_a - alu_b;
      4'd2: alu_result = data_reg_a & alu_b;
      4'd3: alu_result = data_reg_a | alu_b;
      4'd4: alu_result = data_reg_a ^ alu_b;
      4'd5: alu_result = data_reg_a << alu_b[3:0];
      4'd6: alu_result = data_reg_a >> alu_b[3:0];
      4'd7: alu_result = {15'd0, $signed(data_reg_a) < $signed(alu_b)};
      4'd8: alu_result = alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [16:0] sum17;
  logic [16:0] diff17;

  assign sum17  = {1'b0, data_reg_a} + {1'b0, alu_b};
  assign diff17 = {1'b0, data_reg_a} - {1'b0, alu_b};

  assign alu_zero     = (alu_result == 16'h0000);
  assign alu_negative = alu_result[15];

  // SUB carry is the inverted borrow out of the subtraction
  always_comb begin
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    if (alu_ctrl == 4'd0) begin
      alu_carry    = sum17[16];
      alu_overflow = (data_reg_a[15] == alu_b[15]) && (sum17[15] != data_reg_a[15]);
    end else if (alu_ctrl == 4'd1) begin
      alu_carry    = ~diff17[16];
      alu_overflow = (data_reg_a[15] != alu_b[15]) && (diff17[15] != data_reg_a[15]);
    end
  end
`endif

endmodule

// File: tb/tb_pc_decoder_alu16.sv
// tb/tb_pc_decoder_alu16.sv - scoreboard bench for the PC/decoder/ALU slice
module tb_pc_decoder_alu16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic [15:0] data_reg_a = 16'h0000;
  logic [15:0] data_reg_b = 16'h0000;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] pc_out;
  logic [3:0]  alu_ctrl;
  logic [2:0]  reg_dst, reg_rs1, reg_rs2;
  logic [15:0] imm_se;
  logic        reg_write, alu_src_imm, mem_write, mem_read, reg_write_back_sel;
  logic [2:0]  comparator_ctrl;
  logic [15:0] alu_result;
`ifdef ALU_FLAGS_EN
  logic        alu_zero, alu_negative, alu_carry, alu_overflow;
`endif

  pc_decoder_alu16 dut (
    .clk(clk), .rst(rst), .instr(instr),
    .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_out(pc_out), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
    .imm_se(imm_se), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
    .mem_write(mem_write), .mem_read(mem_read),
    .reg_write_back_sel(reg_write_back_sel),
    .comparator_ctrl(comparator_ctrl), .alu_result(alu_result)
`ifdef ALU_FLAGS_EN
    , .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [3:0] S_PC = 0, S_OP = 1, S_RD = 2, S_RS1 = 3, S_RS2 = 4,
                         S_IMM = 5, S_CTL = 6, S_CMP = 7, S_RES = 8, S_FLG = 9;

  function automatic string sel_name(input logic [3:0] sel);
    case (sel)
      S_PC:    return "pc_out";
      S_OP:    return "alu_ctrl";
      S_RD:    return "reg_dst";
      S_RS1:   return "reg_rs1";
      S_RS2:   return "reg_rs2";
      S_IMM:   return "imm_se";
      S_CTL:   return "ctrl{rw,src,mw,mr,wb}";
      S_CMP:   return "comparator_ctrl";
      S_RES:   return "alu_result";
      default: return "flags{z,n,c,v}";
    endcase
  endfunction

  function automatic logic [15:0] observe(input logic [3:0] sel);
    case (sel)
      S_PC:  return pc_out;
      S_OP:  return {12'd0, alu_ctrl};
      S_RD:  return {13'd0, reg_dst};
      S_RS1: return {13'd0, reg_rs1};
      S_RS2: return {13'd0, reg_rs2};
      S_IMM: return imm_se;
      S_CTL: return {11'd0, reg_write, alu_src_imm, mem_write, mem_read, reg_write_back_sel};
      S_CMP: return {13'd0, comparator_ctrl};
      S_RES: return alu_result;
`ifdef ALU_FLAGS_EN
      S_FLG: return {12'd0, alu_zero, alu_negative, alu_carry, alu_overflow};
`endif
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] sel, input logic [15:0] exp);
    sb.push_back('{sel: sel, exp: exp});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(sel_name(e.sel), observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected decode for one instruction, all fields at once
  task automatic push_dec(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [15:0] imm,
                          input logic [4:0] ctl, input logic [2:0] cmp);
    push(S_OP, {12'd0, op});
    push(S_RD, {13'd0, rd});
    push(S_RS1, {13'd0, rs1});
    push(S_RS2, {13'd0, rs2});
    push(S_IMM, imm);
    push(S_CTL, {11'd0, ctl});
    push(S_CMP, {13'd0, cmp});
  endtask

  task automatic apply(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
    instr      = i;
    data_reg_a = a;
    data_reg_b = b;
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ra, rb, r;

    // PC held at reset value while rst is high
    #2;
    push(S_PC, 16'h0000);
    drain();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      push(S_PC, 16'(k));
      drain();
    end

    // JMP with a taken branch loads the target
    instr = 16'hF000; branch_taken = 1'b1; branch_target = 16'h0040;
    tick();
    push(S_PC, 16'h0040);
    drain();

    // Taken verdict ignored for a non-branch instruction
    instr = 16'h0000; branch_target = 16'h1234;
    tick();
    push(S_PC, 16'h0041);
    drain();
    branch_taken = 1'b0;
    tick();
    push(S_PC, 16'h0042);
    drain();

    // Mid-count reset takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    push(S_PC, 16'h0000);
    drain();
    @(negedge clk);
    rst = 1'b0;
    tick();
    push(S_PC, 16'h0001);
    drain();

    // Wrap-around from 0xFFFF
    instr = 16'hF000; branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    push(S_PC, 16'hFFFF);
    drain();
    instr = 16'h0000; branch_taken = 1'b0;
    tick();
    push(S_PC, 16'h0000);
    drain();

    // Decoder and ALU directed cases
    apply(16'h1650, 16'h0005, 16'h0007);
    push_dec(4'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 5'b10000, 3'b000);
    push(S_RES, 16'h000C);
`ifdef ALU_FLAGS_EN
    push(S_FLG, 16'h0000);
`endif
    drain();

    apply(16'h947F, 16'h0010, 16'h1234);
    push_dec(4'd0, 3'd2, 3'd1, 3'd0, 16'hFFFF, 5'b11000, 3'b000);
    push(S_RES, 16'h000F);
    drain();

    apply(16'hFABC, 16'h1111, 16'h2222);
    push_dec(4'd0, 3'd0, 3'd0, 3'd0, 16'h0ABC, 5'b00000, 3'b100);
    drain();

    apply(16'hA8BE, 16'h0100, 16'h5555);
    push_dec(4'd0, 3'd4, 3'd2, 3'd0, 16'hFFFE, 5'b11011, 3'b000);
    push(S_RES, 16'h00FE);
    drain();

    apply(16'hBAC4, 16'h0010, 16'h5555);
    push_dec(4'd0, 3'd0, 3'd3, 3'd5, 16'h0004, 5'b01100, 3'b000);
    push(S_RES, 16'h0014);
    drain();

    apply(16'hCF00, 16'h1234, 16'h5555);
    push_dec(4'd8, 3'd7, 3'd0, 3'd0, 16'hFF00, 5'b11000, 3'b000);
    push(S_RES, 16'hFF00);
    drain();

    apply(16'hD2A0, 16'h1234, 16'h5555);
    push_dec(4'd0, 3'd0, 3'd1, 3'd2, 16'hFFE0, 5'b00000, 3'b001);
    drain();

    apply(16'hE2A0, 16'h1234, 16'h5555);
    push(S_CMP, 16'h0002);
    drain();

    apply(16'h0000, 16'hABCD, 16'h1234);
    push_dec(4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 5'b00000, 3'b000);
    drain();

    // ALU corners
    apply(16'h2000, 16'h0000, 16'h0001);
    push(S_OP, 16'h0001);
    push(S_RES, 16'hFFFF);
`ifdef ALU_FLAGS_EN
    push(S_FLG, 16'h0004);
`endif
    drain();

    apply(16'h8000, 16'h8000, 16'h0001);
    push(S_OP, 16'h0007);
    push(S_RES, 16'h0001);
    drain();

    apply(16'h6000, 16'h0001, 16'h000F);
    push(S_OP, 16'h0005);
    push(S_RES, 16'h8000);
    drain();

    apply(16'h7000, 16'h8000, 16'h000F);
    push(S_RES, 16'h0001);
    drain();

    // Random register-register operations against a behavioural model
    for (int n = 0; n < 16; n++) begin
      op = 4'($urandom_range(1, 8));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (op)
        4'd1: r = ra + rb;
        4'd2: r = ra - rb;
        4'd3: r = ra & rb;
        4'd4: r = ra | rb;
        4'd5: r = ra ^ rb;
        4'd6: r = ra << rb[3:0];
        4'd7: r = ra >> rb[3:0];
        default: r = ($signed(ra) < $signed(rb)) ? 16'h0001 : 16'h0000;
      endcase
      apply({op, 12'h0}, ra, rb);
      push(S_RES, r);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
